// File: rtl/cordic_vector_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cordic_vector_pipe_pkg
// Description : Shared definitions for the CORDIC vectoring pipeline:
//               the quadrant code type, the whole-degree phase constants,
//               the phase scaling helper and the arctangent table function.
// Revision    : 1.0 - initial release
// ============================================================================
package cordic_vector_pipe_pkg;

    // Quadrant code {x_in<0, y_in<0} captured by the fold stage.
    typedef enum logic [1:0] {
        QUAD_I   = 2'b00,
        QUAD_IV  = 2'b01,
        QUAD_II  = 2'b10,
        QUAD_III = 2'b11
    } quad_e;

    localparam int DEG_90  = 90;
    localparam int DEG_180 = 180;
    localparam int DEG_270 = 270;
    localparam int DEG_360 = 360;

    // Whole-degree angle expressed in phase LSBs (frac fractional bits).
    function automatic int phase_lsb(input int deg, input int frac);
        return deg * (1 << frac);
    endfunction

    // atan(2^-idx) in degrees, truncated to frac fractional bits.
    // Evaluated only at elaboration to build the per-stage constants.
    function automatic int atan_lsb(input int idx, input int frac);
        real deg;
        real scale;
        case (idx)
            0:  deg = 45.0;
            1:  deg = 26.565051177077990;
            2:  deg = 14.036243467926479;
            3:  deg = 7.125016348901798;
            4:  deg = 3.576334374997352;
            5:  deg = 1.789910608246069;
            6:  deg = 0.895173710211074;
            7:  deg = 0.447614170860553;
            8:  deg = 0.223810500368538;
            9:  deg = 0.111905677066207;
            10: deg = 0.055952891893804;
            11: deg = 0.027976452617004;
            12: deg = 0.013988227142265;
            13: deg = 0.006994113675353;
            14: deg = 0.003497056850704;
            15: deg = 0.001748528426980;
            default: begin
                // Beyond the table atan(2^-i) halves per step to well
                // below one LSB of any practical phase format.
                deg = 0.001748528426980;
                for (int k = 15; k < idx; k++) begin
                    deg = deg / 2.0;
                end
            end
        endcase
        scale = 1.0;
        for (int k = 0; k < frac; k++) begin
            scale = scale * 2.0;
        end
        return $rtoi(deg * scale);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_vec_stage.sv
`default_nettype none
// ============================================================================
// Module      : cordic_vec_stage
// Description : One registered CORDIC vectoring micro-rotation. Drives y
//               toward zero and accumulates the applied rotation in z.
// Ports       : clk, rst        clock, async active-high reset
//               adv             pipeline advance enable
//               prev_*          previous stage valid/x/y/z/quadrant
//               valid,x,y,z,q   this stage's registered result
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_vec_stage
    import cordic_vector_pipe_pkg::*;
#(
    parameter int XW    = 18,
    parameter int ZW    = 18,
    parameter int STAGE = 0,
    parameter int ATAN  = 0
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 adv,
    input  logic                 prev_valid,
    input  logic signed [XW-1:0] prev_x,
    input  logic signed [XW-1:0] prev_y,
    input  logic signed [ZW-1:0] prev_z,
    input  quad_e                prev_q,
    output logic                 valid,
    output logic signed [XW-1:0] x,
    output logic signed [XW-1:0] y,
    output logic signed [ZW-1:0] z,
    output quad_e                q
);

    localparam logic signed [ZW-1:0] c_atan = ZW'(ATAN);

    logic signed [XW-1:0] w_x_shift;
    logic signed [XW-1:0] w_y_shift;
    logic                 w_y_nonneg;

    assign w_x_shift  = prev_x >>> STAGE;
    assign w_y_shift  = prev_y >>> STAGE;
    assign w_y_nonneg = ~prev_y[XW-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            x     <= '0;
            y     <= '0;
            z     <= '0;
            q     <= QUAD_I;
        end else if (adv) begin
            valid <= prev_valid;
            q     <= prev_q;
            if (w_y_nonneg) begin
                x <= prev_x + w_y_shift;
                y <= prev_y - w_x_shift;
                z <= prev_z + c_atan;
            end else begin
                x <= prev_x - w_y_shift;
                y <= prev_y + w_x_shift;
                z <= prev_z - c_atan;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cordic_vector_pipe.sv
`default_nettype none
// ============================================================================
// Module      : cordic_vector_pipe
// Description : Fully pipelined CORDIC vectoring engine. Returns the angle
//               of (x_in, y_in) in [0,360) degrees and the gain-scaled
//               magnitude. Latency ITERATIONS+2 advancing cycles.
// Ports       : clk, rst             clock, async active-high reset
//               in_valid/in_ready    input handshake
//               x_in, y_in           signed input vector
//               out_valid/out_ready  output handshake
//               z_out                unsigned phase, PHASE_FRAC frac bits
//               mag_out              |(x,y)| times CORDIC gain, unsigned
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_vector_pipe
    import cordic_vector_pipe_pkg::*;
#(
    parameter int WORD_WIDTH  = 16,
    parameter int PHASE_WIDTH = 16,
    parameter int PHASE_FRAC  = 7,
    parameter int ITERATIONS  = 14
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [WORD_WIDTH-1:0] x_in,
    input  logic signed [WORD_WIDTH-1:0] y_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PHASE_WIDTH-1:0]       z_out,
    output logic [WORD_WIDTH+1:0]        mag_out
);

    localparam int XW = WORD_WIDTH + 2;
    // Two extra bits: one for the sign of the running angle, one so
    // 360+small overshoots are representable before wrapping.
    localparam int ZW = PHASE_WIDTH + 2;

    localparam logic signed [ZW-1:0] c_180 = ZW'(phase_lsb(DEG_180, PHASE_FRAC));
    localparam logic signed [ZW-1:0] c_360 = ZW'(phase_lsb(DEG_360, PHASE_FRAC));

    logic w_adv;

    // Stage 0 of these arrays is the fold register; stage i+1 is rotation i.
    logic                 w_v [0:ITERATIONS];
    logic signed [XW-1:0] w_x [0:ITERATIONS];
    logic signed [XW-1:0] w_y [0:ITERATIONS];
    logic signed [ZW-1:0] w_z [0:ITERATIONS];
    quad_e                w_q [0:ITERATIONS];

    logic                 r_f_valid;
    logic signed [XW-1:0] r_f_x;
    logic signed [XW-1:0] r_f_y;
    quad_e                r_f_q;

    logic signed [XW-1:0] w_x_ext;
    logic signed [XW-1:0] w_y_ext;
    logic signed [XW-1:0] w_x_abs;
    logic signed [XW-1:0] w_y_abs;

    logic signed [ZW-1:0] w_z_fin;
    logic signed [ZW-1:0] w_z_corr;
    logic signed [ZW-1:0] w_z_wrap;
    logic                 w_unused_y;

    // A stalled consumer freezes the whole pipe, so input acceptance
    // follows the same enable.
    assign w_adv    = out_ready | ~out_valid;
    assign in_ready = w_adv;

    // Two guard bits make |most-negative| exactly representable.
    assign w_x_ext = XW'(x_in);
    assign w_y_ext = XW'(y_in);
    assign w_x_abs = x_in[WORD_WIDTH-1] ? -w_x_ext : w_x_ext;
    assign w_y_abs = y_in[WORD_WIDTH-1] ? -w_y_ext : w_y_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f_valid <= 1'b0;
            r_f_x     <= '0;
            r_f_y     <= '0;
            r_f_q     <= QUAD_I;
        end else if (w_adv) begin
            r_f_valid <= in_valid;
            r_f_x     <= w_x_abs;
            r_f_y     <= w_y_abs;
            r_f_q     <= quad_e'({x_in[WORD_WIDTH-1], y_in[WORD_WIDTH-1]});
        end
    end

    assign w_v[0] = r_f_valid;
    assign w_x[0] = r_f_x;
    assign w_y[0] = r_f_y;
    assign w_z[0] = '0;
    assign w_q[0] = r_f_q;

    generate
        for (genvar g = 0; g < ITERATIONS; g++) begin : g_stage
            cordic_vec_stage #(
                .XW    (XW),
                .ZW    (ZW),
                .STAGE (g),
                .ATAN  (atan_lsb(g, PHASE_FRAC))
            ) u_stage (
                .clk        (clk),
                .rst        (rst),
                .adv        (w_adv),
                .prev_valid (w_v[g]),
                .prev_x     (w_x[g]),
                .prev_y     (w_y[g]),
                .prev_z     (w_z[g]),
                .prev_q     (w_q[g]),
                .valid      (w_v[g+1]),
                .x          (w_x[g+1]),
                .y          (w_y[g+1]),
                .z          (w_z[g+1]),
                .q          (w_q[g+1])
            );
        end
    endgenerate

    // The residual y after the last rotation carries no information.
    assign w_unused_y = ^w_y[ITERATIONS];

    // Map the first-quadrant angle back to the original quadrant, then
    // fold the result into [0,360). The accumulated angle can land a few
    // LSBs either side of an axis, so both directions are wrapped.
    always_comb begin
        w_z_fin  = w_z[ITERATIONS];
        w_z_corr = w_z_fin;
        case (w_q[ITERATIONS])
            QUAD_I:   w_z_corr = w_z_fin;
            QUAD_II:  w_z_corr = c_180 - w_z_fin;
            QUAD_III: w_z_corr = c_180 + w_z_fin;
            QUAD_IV:  w_z_corr = c_360 - w_z_fin;
            default:  w_z_corr = w_z_fin;
        endcase

        if (w_z_corr[ZW-1]) begin
            w_z_wrap = w_z_corr + c_360;
        end else if (w_z_corr >= c_360) begin
            w_z_wrap = w_z_corr - c_360;
        end else begin
            w_z_wrap = w_z_corr;
        end

        // x only grows in vectoring mode, so a zero final x means a zero
        // input vector; its angle is defined as 0 rather than the sum of
        // every table entry that the rotations would otherwise leave.
        if (w_x[ITERATIONS] == '0) begin
            w_z_wrap = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            z_out     <= '0;
            mag_out   <= '0;
        end else if (w_adv) begin
            out_valid <= w_v[ITERATIONS];
            z_out     <= w_z_wrap[PHASE_WIDTH-1:0];
            mag_out   <= $unsigned(w_x[ITERATIONS]);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cordic_vector_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_vector_pipe
// Description : Scoreboard bench for cordic_vector_pipe. The driver pushes
//               the expected result of every accepted sample; a negedge
//               monitor pops and compares whenever an output transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_vector_pipe;

    localparam int  W    = 16;
    localparam int  PW   = 16;
    localparam int  FRAC = 7;
    localparam int  ITER = 14;
    localparam int  LAT  = ITER + 2;
    localparam int  Z360 = 360 * (1 << FRAC);
    localparam real PI   = 3.14159265358979323846;

    logic                clk       = 1'b0;
    logic                rst       = 1'b1;
    logic                in_valid  = 1'b0;
    logic                out_ready = 1'b1;
    logic signed [W-1:0] x_in      = '0;
    logic signed [W-1:0] y_in      = '0;
    logic                in_ready;
    logic                out_valid;
    logic [PW-1:0]       z_out;
    logic [W+1:0]        mag_out;

    cordic_vector_pipe #(
        .WORD_WIDTH  (W),
        .PHASE_WIDTH (PW),
        .PHASE_FRAC  (FRAC),
        .ITERATIONS  (ITER)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z_out     (z_out),
        .mag_out   (mag_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     x;
        int     y;
        int     z;
        int     mag;
        longint adv;
        bit     ideal;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_checks   = 0;
    int            n_fail     = 0;
    longint        cyc        = 0;
    longint        adv_cnt    = 0;
    bit            adv_seen   = 1'b0;
    longint        atan_tab[ITER];
    real           gain;
    int            or_mode    = 0;
    longint        stall_lo   = 0;
    longint        stall_hi   = -1;
    bit            stall_prev = 1'b0;
    logic [PW-1:0] held_z;
    logic [W+1:0]  held_mag;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // Vectoring algorithm applied sample-by-sample in plain integer math.
    function automatic void ref_model(input int x, input int y, output int z, output int mag);
        longint xa, ya, nx, ny, zz;
        xa = (x < 0) ? -longint'(x) : longint'(x);
        ya = (y < 0) ? -longint'(y) : longint'(y);
        zz = 0;
        for (int i = 0; i < ITER; i++) begin
            if (ya >= 0) begin
                nx = xa + (ya >>> i);
                ny = ya - (xa >>> i);
                zz = zz + atan_tab[i];
            end else begin
                nx = xa - (ya >>> i);
                ny = ya + (xa >>> i);
                zz = zz - atan_tab[i];
            end
            xa = nx;
            ya = ny;
        end
        if (x < 0 && y >= 0)      zz = 180 * (1 << FRAC) - zz;
        else if (x < 0 && y < 0)  zz = 180 * (1 << FRAC) + zz;
        else if (x >= 0 && y < 0) zz = Z360 - zz;
        if (x == 0 && y == 0) zz = 0;
        zz = zz % Z360;
        if (zz < 0) zz = zz + Z360;
        z   = int'(zz);
        mag = int'(xa);
    endfunction

    task automatic send(input int x, input int y, input bit ideal);
        exp_t e;
        bit   acc;
        int   ez, em;
        acc = 1'b0;
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        x_in     = W'(x);
        y_in     = W'(y);
        ref_model(x, y, ez, em);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (acc) begin
            e.x = x; e.y = y; e.z = ez; e.mag = em; e.adv = adv_cnt; e.ideal = ideal;
            sb.push_back(e);
        end else begin
            check(1'b0, "in_ready_timeout", 0, 1);
        end
    endtask

    task automatic go_idle();
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        check(sb.size() == 0, "drain_pending", sb.size(), 0);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (adv_seen) adv_cnt <= adv_cnt + 1;
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Output monitor: hold check while stalled, scoreboard pop on transfer.
    always @(negedge clk) begin
        real ia, im, d;
        adv_seen = out_ready || !out_valid;
        if (stall_prev) begin
            check(out_valid === 1'b1, "stall_valid_hold", longint'(out_valid), 1);
            check(z_out == held_z, "stall_z_hold", z_out, held_z);
            check(mag_out == held_mag, "stall_mag_hold", mag_out, held_mag);
        end
        stall_prev = out_valid && !out_ready && !rst;
        held_z     = z_out;
        held_mag   = mag_out;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check(1'b0, "unexpected_output", z_out, -1);
            end else begin
                mon_e = sb.pop_front();
                check(z_out == PW'(mon_e.z), "z_exact", z_out, mon_e.z);
                check(mag_out == (W+2)'(mon_e.mag), "mag_exact", mag_out, mon_e.mag);
                check(adv_cnt - mon_e.adv == LAT, "latency", adv_cnt - mon_e.adv, LAT);
                check(z_out < Z360, "z_below_360", z_out, Z360 - 1);
                if (mon_e.ideal) begin
                    ia = $atan2(real'(mon_e.y), real'(mon_e.x)) * 180.0 / PI;
                    if (ia < 0.0) ia = ia + 360.0;
                    ia = ia * real'(1 << FRAC);
                    d  = real'(z_out) - ia;
                    if (d > real'(Z360 / 2))  d = d - real'(Z360);
                    if (d < -real'(Z360 / 2)) d = d + real'(Z360);
                    check(d <= 8.0 && d >= -8.0, "z_vs_ideal", z_out, $rtoi(ia));
                    im = $sqrt(real'(mon_e.x) * real'(mon_e.x) + real'(mon_e.y) * real'(mon_e.y)) * gain;
                    d  = real'(mag_out) - im;
                    check(d <= 8.0 + 0.005 * im && d >= -(8.0 + 0.005 * im),
                          "mag_vs_ideal", mag_out, $rtoi(im));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        real p;
        int  rx, ry;
        bit  bad;
        p    = 1.0;
        gain = 1.0;
        for (int i = 0; i < ITER; i++) begin
            atan_tab[i] = $rtoi($atan(p) * 180.0 / PI * real'(1 << FRAC) + 1.0e-9);
            gain        = gain * $sqrt(1.0 + p * p);
            p           = p / 2.0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check(out_valid == 1'b0, "rst_out_valid", longint'(out_valid), 0);
        check(in_ready == 1'b1, "rst_in_ready", longint'(in_ready), 1);
        check(z_out == '0, "rst_z_out", z_out, 0);
        check(mag_out == '0, "rst_mag_out", mag_out, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Directed vectors, including axis, diagonal, wrap and full-scale
        send(1000, 0, 1'b1);
        send(1000, 1000, 1'b1);
        send(-1000, 1000, 1'b1);
        send(-1000, -1000, 1'b1);
        send(0, -1000, 1'b1);
        send(1000, -1, 1'b1);
        send(-32768, -32768, 1'b1);
        send(0, 0, 1'b1);
        send(32767, -32768, 1'b1);
        send(0, 1000, 1'b1);
        go_idle();
        drain();

        // 20-sample stream with a 3-cycle consumer stall mid-stream
        stall_lo = cyc + 20;
        stall_hi = cyc + 22;
        or_mode  = 1;
        for (int n = 0; n < 20; n++) begin
            rx = int'($urandom_range(0, 65535)) - 32768;
            ry = int'($urandom_range(0, 65535)) - 32768;
            send(rx, ry, 1'b0);
        end
        go_idle();
        drain();
        or_mode = 0;

        // Reset with samples in flight: they must never appear
        for (int n = 0; n < 5; n++) begin
            send(2000 + n, -300 * n, 1'b0);
        end
        go_idle();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check(out_valid == 1'b0, "async_rst_out_valid", longint'(out_valid), 0);
        check(in_ready == 1'b1, "async_rst_in_ready", longint'(in_ready), 1);
        check(z_out == '0, "async_rst_z_out", z_out, 0);
        check(mag_out == '0, "async_rst_mag_out", mag_out, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (out_valid) bad = 1'b1;
        end
        check(!bad, "flushed_samples_silent", longint'(bad), 0);
        send(1000, 1000, 1'b1);
        go_idle();
        drain();

        // Random traffic with random backpressure and input gaps
        or_mode = 2;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 4) == 0) go_idle();
            rx = int'($urandom_range(0, 65535)) - 32768;
            ry = int'($urandom_range(0, 65535)) - 32768;
            send(rx, ry, 1'b0);
        end
        go_idle();
        or_mode = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
